and2_checker: RTL and testbench
===============================

AND2_CHECKER -- requirements
Module: and2_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from stimulus (a,b) sampled to matching q of the registered AND stage under a single shared clock; legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the vector and error counters.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a check run.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that ends stimulus acceptance and begins drain.
REQ-007 SHALL have port vld  input  1  a/b valid this cycle.
REQ-008 SHALL have ports a and b  input  1 each  stimulus bits driven into the registered AND stage.
REQ-009 SHALL have port q  input  1  registered AND output under check.
REQ-010 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port pass  output  1  run verdict, valid while done=1.
REQ-013 SHALL have ports vec_cnt and err_cnt  output  CNT_W each  compared vectors and mismatches.
REQ-014 SHALL have port first_err_idx  output  CNT_W  vec_cnt value at the first mismatch.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->DONE when the expectation pipeline holds no valid entry; DONE->RUN on start.
REQ-016 SHALL, on every IDLE->RUN or DONE->RUN transition, clear vec_cnt, err_cnt, first_err_idx (to all-ones) and all pipeline valid bits in the same cycle.
REQ-017 SHALL ignore start while in RUN or DRAIN, and ignore stop outside RUN.
REQ-018 SHALL, in RUN only, load {vld, a&b} into a LATENCY-deep shift pipeline each cycle; outside RUN, load valid=0.
REQ-019 SHALL, when the pipeline tail is valid, compare q to the expected bit in that cycle, increment vec_cnt, and increment err_cnt on mismatch.
REQ-020 SHALL saturate vec_cnt and err_cnt at all-ones, with no wrap-around.
REQ-021 SHALL, when stop and vld are asserted in the same RUN cycle, accept that vector and then enter DRAIN.
REQ-022 SHALL drive pass = (err_cnt==0) AND (vec_cnt!=0) in DONE, and pass=0 in every other state.
REQ-023 SHALL make busy, done, pass and the counters registered outputs, and the counters SHALL hold their values in DONE until the next start.

Reset
REQ-024 SHALL, on rst=1 at posedge clk in any state including mid-run, set the FSM to IDLE, clear all pipeline valid bits, set busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, first_err_idx=all-ones.
REQ-025 SHALL give rst priority over start, stop and vld in the same cycle.

Configuration
REQ-026 SHALL use the macro AND2_CHECKER_FIRST_ERR_EN: when defined, first_err_idx captures the pre-increment vec_cnt at the first mismatch of a run and holds it until the next clear.
REQ-027 SHALL, without AND2_CHECKER_FIRST_ERR_EN, drive first_err_idx constant all-ones and synthesize no capture register, while all other behaviour is unchanged.

Verification
REQ-028 SHALL cover: with LATENCY=2, start, 4 vectors (00,01,10,11) with q equal to correct AND delayed 2 cycles, then stop -> done=1 two cycles after the last tail compare, vec_cnt=4, err_cnt=0, pass=1.
REQ-029 SHALL cover: the same 4 vectors with q forced to 1 on vector index 1 -> err_cnt=1, pass=0, first_err_idx=1 when the macro is defined, or 0xFFFF when it is not.
REQ-030 SHALL cover: start immediately followed by stop with no vld -> DONE with vec_cnt=0 and pass=0.
REQ-031 SHALL cover: rst asserted during RUN after 3 vectors -> all outputs reach reset values on the next cycle, and later q activity does not change the counters.
REQ-032 SHALL cover: CNT_W=4 with 20 mismatching vectors -> err_cnt=15 and vec_cnt=15, both saturated.
REQ-033 SHALL cover: start pulse while in RUN -> no counter clear; stop and vld in the same cycle -> that vector is counted.

Source files
------------

// File: rtl/and2_checker_if.sv
// Bundle of the stimulus, observed-output and result signals of and2_checker.
// master: the side that drives stimulus and the q under check.
// slave:  the checker itself.
interface and2_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             vld;
  logic             a;
  logic             b;
  logic             q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, stop, vld, a, b, q,
    input  busy, done, pass, vec_cnt, err_cnt, first_err_idx
  );

  modport slave (
    input  start, stop, vld, a, b, q,
    output busy, done, pass, vec_cnt, err_cnt, first_err_idx
  );
endinterface

// File: rtl/and2_checker.sv
// and2_checker: checks a registered AND stage by predicting a&b, delaying the
// prediction LATENCY cycles and comparing it with the observed q.
// Optional feature macro: AND2_CHECKER_FIRST_ERR_EN (capture the vector index
// of the first mismatch of a run; otherwise first_err_idx is tied to all-ones).
module and2_checker #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  and2_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [LATENCY-1:0] pv_q, pv_d;   // expectation valid bits, [0] = newest
  logic [LATENCY-1:0] pe_q, pe_d;   // expected q bits
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               busy_q, done_q, pass_q;
  logic               clear;
  logic               tail_v;
  logic               mismatch;

  // A new run starts only from IDLE or DONE; start is ignored while busy.
  assign clear    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign tail_v   = pv_q[LATENCY-1];
  assign mismatch = tail_v && (bus.q != pe_q[LATENCY-1]);

  // Stage 0 only accepts vectors while running; a stop cycle is still RUN,
  // so a vector arriving together with stop is kept.
  assign pv_d[0] = (state_q == RUN) && bus.vld;
  assign pe_d[0] = bus.a & bus.b;

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_pipe
      assign pv_d[gi] = pv_q[gi-1] && !clear;
      assign pe_d[gi] = pe_q[gi-1];
    end
  endgenerate

  // Next-state logic of the run controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.stop)  state_d = DRAIN;
      DRAIN:   if (pv_q == '0) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Saturating vector / error counters, cleared at the start of each run.
  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    if (clear) begin
      vec_d = '0;
      err_d = '0;
    end else begin
      if (tail_v && (vec_q != CNT_MAX))   vec_d = vec_q + 1'b1;
      if (mismatch && (err_q != CNT_MAX)) err_d = err_q + 1'b1;
    end
  end

  // State, pipeline, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pv_q    <= '0;
      pe_q    <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      busy_q  <= (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      pass_q  <= (state_d == DONE) && (err_d == '0) && (vec_d != '0);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.vec_cnt = vec_q;
  assign bus.err_cnt = err_q;

`ifdef AND2_CHECKER_FIRST_ERR_EN
  logic [CNT_W-1:0] first_q, first_d;

  // Latch the pre-increment vector count at the first mismatch of a run.
  always_comb begin
    first_d = first_q;
    if (clear)                          first_d = '1;
    else if (mismatch && (err_q == '0)) first_d = vec_q;
  end

  // First-error index register.
  always_ff @(posedge clk) begin
    if (rst) first_q <= '1;
    else     first_q <= first_d;
  end

  assign bus.first_err_idx = first_q;
`else
  assign bus.first_err_idx = '1;
`endif

endmodule

// File: tb/tb_and2_checker.sv
// Testbench for and2_checker: two instances (LATENCY=2/CNT_W=16 and
// LATENCY=3/CNT_W=4) receive identical stimulus; each gets its own q stream.
module tb_and2_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  and2_checker_if #(.CNT_W(16)) bus0 ();
  and2_checker_if #(.CNT_W(4))  bus1 ();

  and2_checker #(.LATENCY(2), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  and2_checker #(.LATENCY(3), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is a list of accepted vectors; q for each vector is
  // scheduled LATENCY cycles after it is driven, optionally inverted.
  int cyc = 0;
  bit sched0 [0:4095];
  bit sched1 [0:4095];
  bit run_m  = 1'b0;
  int mvec   = 0;
  int merr   = 0;
  int mfirst = -1;

  typedef struct {
    bit st, sp, v, a, b;
    bit eb, ed, ep;
    int ev;
  } row_t;
  row_t tbl [11];

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge and update the model.
  task automatic step(input bit r, input bit st, input bit sp, input bit v,
                      input bit ia, input bit ib, input bit f);
    @(negedge clk);
    rst = r;
    bus0.start = st; bus0.stop = sp; bus0.vld = v; bus0.a = ia; bus0.b = ib;
    bus1.start = st; bus1.stop = sp; bus1.vld = v; bus1.a = ia; bus1.b = ib;
    bus0.q = sched0[cyc];
    bus1.q = sched1[cyc];
    if (r) begin
      run_m = 1'b0; mvec = 0; merr = 0; mfirst = -1;
    end else begin
      if (run_m && v) begin
        sched0[cyc+2] = (ia & ib) ^ f;
        sched1[cyc+3] = (ia & ib) ^ f;
        if (f && mfirst < 0) mfirst = mvec;
        mvec++;
        if (f) merr++;
      end
      if (run_m && sp) run_m = 1'b0;
      else if (!run_m && st) begin
        run_m = 1'b1; mvec = 0; merr = 0; mfirst = -1;
      end
    end
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus0.done && bus1.done) break;
      idle();
    end
    if (!(bus0.done && bus1.done)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done0=%0b done1=%0b expected both 1", name, bus0.done, bus1.done);
    end
  endtask

  task automatic check_final(input string name);
    int ef0, ef1;
`ifdef AND2_CHECKER_FIRST_ERR_EN
    ef0 = (mfirst < 0) ? 16'hFFFF : sat(mfirst, 16'hFFFF);
    ef1 = (mfirst < 0) ? 4'hF : sat(mfirst, 4'hF);
`else
    ef0 = 16'hFFFF;
    ef1 = 4'hF;
`endif
    chk({name, "_done0"}, int'(bus0.done), 1);
    chk({name, "_busy0"}, int'(bus0.busy), 0);
    chk({name, "_vec0"},  int'(bus0.vec_cnt), sat(mvec, 16'hFFFF));
    chk({name, "_err0"},  int'(bus0.err_cnt), sat(merr, 16'hFFFF));
    chk({name, "_pass0"}, int'(bus0.pass), int'(merr == 0 && mvec != 0));
    chk({name, "_first0"}, int'(bus0.first_err_idx), ef0);
    chk({name, "_done1"}, int'(bus1.done), 1);
    chk({name, "_vec1"},  int'(bus1.vec_cnt), sat(mvec, 4'hF));
    chk({name, "_err1"},  int'(bus1.err_cnt), sat(merr, 4'hF));
    chk({name, "_pass1"}, int'(bus1.pass), int'(merr == 0 && mvec != 0));
    chk({name, "_first1"}, int'(bus1.first_err_idx), ef1);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_busy"},  int'(bus0.busy), 0);
    chk({name, "_done"},  int'(bus0.done), 0);
    chk({name, "_pass"},  int'(bus0.pass), 0);
    chk({name, "_vec0"},  int'(bus0.vec_cnt), 0);
    chk({name, "_err0"},  int'(bus0.err_cnt), 0);
    chk({name, "_first0"}, int'(bus0.first_err_idx), 16'hFFFF);
    chk({name, "_vec1"},  int'(bus1.vec_cnt), 0);
    chk({name, "_first1"}, int'(bus1.first_err_idx), 4'hF);
  endtask

  initial begin
    // Rows: inputs, then outputs of dut0 seen before this row's clock edge.
    //            st sp v  a  b   busy done pass vec
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0,  1, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 1,  1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0,  1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 1,  1, 0, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 0,  1, 0, 0, 2};
    tbl[7]  = '{0, 0, 0, 0, 0,  1, 0, 0, 3};
    tbl[8]  = '{0, 0, 0, 0, 0,  1, 0, 0, 4};
    tbl[9]  = '{0, 0, 0, 0, 0,  0, 1, 1, 4};
    tbl[10] = '{0, 0, 0, 0, 0,  0, 1, 1, 4};

    for (int i = 0; i < 4096; i++) begin
      sched0[i] = 1'($urandom);
      sched1[i] = 1'($urandom);
    end

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_reset("reset");

    // Basic run: 00,01,10,11 with correct q, then stop.
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].a, tbl[i].b, 0);
      chk($sformatf("tbl%0d_busy", i), int'(bus0.busy), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_done", i), int'(bus0.done), int'(tbl[i].ed));
      chk($sformatf("tbl%0d_pass", i), int'(bus0.pass), int'(tbl[i].ep));
      chk($sformatf("tbl%0d_vec", i),  int'(bus0.vec_cnt), tbl[i].ev);
      chk($sformatf("tbl%0d_err", i),  int'(bus0.err_cnt), 0);
    end
    wait_done("basic");
    check_final("basic");

    // Same vectors, q forced to 1 on vector index 1.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    wait_done("err1");
    check_final("err1");

    // Start then immediately stop: empty run.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    wait_done("empty");
    check_final("empty");

    // Start ignored mid-run; vector with stop is counted.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    wait_done("startrun");
    check_final("startrun");

    // 20 mismatching vectors: dut1 counters saturate at 15.
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(0, 0, i == 19, 1, 1'($urandom), 1'($urandom), 1);
    wait_done("sat");
    check_final("sat");

    // Reset in the middle of a run, with vld asserted alongside.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_reset("midrst");
    for (int i = 0; i < 6; i++) idle();
    check_reset("postrst");

    // Randomized runs checked against the model.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(4, 30);
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++)
        step(0, $urandom_range(0, 9) == 0, i == n - 1, 1'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      wait_done($sformatf("rnd%0d", r));
      check_final($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
